// File: rtl/riscv_dp_bypass.sv
// Operand bypass and load-use interlock for an in-order RISC-V datapath.
// A short shift register of slots tracks the destination of every
// instruction in flight. Each decode source is resolved against the
// youngest matching slot. A load that is still too young to forward
// stalls decode until its data reaches the load-ready slot.
module riscv_dp_bypass #(
    parameter int MP_DATA_WIDTH         = 32,
    parameter int MP_REGFILE_ADDR_WIDTH = 5,
    parameter int MP_NUM_SRC            = 2,
    parameter int MP_FWD_DEPTH          = 3,
    parameter int MP_LOAD_READY_SLOT    = 2
) (
    input  logic                                      iclk,
    input  logic                                      irst,
    input  logic                                      iissue_valid,
    input  logic [MP_REGFILE_ADDR_WIDTH-1:0]          iissue_rd,
    input  logic                                      iissue_rd_wr_en,
    input  logic                                      iissue_is_load,
    input  logic                                      iflush,
    input  logic [MP_NUM_SRC*MP_REGFILE_ADDR_WIDTH-1:0] isrc_addr,
    input  logic [MP_NUM_SRC*MP_DATA_WIDTH-1:0]       isrc_rf_data,
    input  logic [MP_FWD_DEPTH*MP_DATA_WIDTH-1:0]     islot_result,
    output logic [MP_NUM_SRC*MP_DATA_WIDTH-1:0]       osrc_data,
    output logic [MP_NUM_SRC-1:0]                     osrc_fwd,
    output logic                                      ostall,
    output logic [31:0]                               ostall_cnt
);

    localparam int AW = MP_REGFILE_ADDR_WIDTH;
    localparam int DW = MP_DATA_WIDTH;
    localparam int FD = MP_FWD_DEPTH;

    // Slot state: slot 0 is execute, higher indices are older.
    logic [FD-1:0] slot_valid_reg;
    logic [FD-1:0] slot_wr_en_reg;
    logic [FD-1:0] slot_is_load_reg;
    logic [AW-1:0] slot_rd_reg [FD];

    logic [31:0]           stall_cnt_reg;
    logic [MP_NUM_SRC-1:0] src_wait;
    logic                  stall;
    logic                  issue_accept;

    genvar gi;
    generate
        for (gi = 0; gi < MP_NUM_SRC; gi++) begin : g_src
            logic [AW-1:0] addr;
            logic [DW-1:0] rf_data;
            logic [DW-1:0] data;
            logic          fwd;
            logic          wait_hit;
            logic          found;

            assign addr    = isrc_addr[gi*AW +: AW];
            assign rf_data = isrc_rf_data[gi*DW +: DW];

            // Resolve this source against the youngest matching slot.
            always_comb begin
                data     = rf_data;
                fwd      = 1'b0;
                wait_hit = 1'b0;
                found    = 1'b0;
                for (int j = 0; j < FD; j++) begin
                    if (!found && slot_valid_reg[j] && slot_wr_en_reg[j] &&
                        (slot_rd_reg[j] == addr)) begin
                        found = 1'b1;
                        if (!slot_is_load_reg[j] || (j >= MP_LOAD_READY_SLOT)) begin
                            data = islot_result[j*DW +: DW];
                            fwd  = 1'b1;
                        end else begin
                            // Load data not available yet; value is irrelevant
                            // because decode is held.
                            wait_hit = 1'b1;
                        end
                    end
                end
                // x0 is hard-wired to zero and never forwarded.
                if (addr == '0) begin
                    data     = '0;
                    fwd      = 1'b0;
                    wait_hit = 1'b0;
                end
            end

            assign osrc_data[gi*DW +: DW] = data;
            assign osrc_fwd[gi]           = fwd;
            assign src_wait[gi]           = wait_hit;
        end
    endgenerate

    // A flushed or empty decode slot can never stall.
    assign stall        = iissue_valid && !iflush && (|src_wait);
    assign issue_accept = iissue_valid && !iflush && !stall;
    assign ostall       = stall;
    assign ostall_cnt   = stall_cnt_reg;

    // Advance the in-flight tracking slots; decode enters slot 0 or a bubble does.
    always_ff @(posedge iclk) begin
        if (irst) begin
            slot_valid_reg   <= '0;
            slot_wr_en_reg   <= '0;
            slot_is_load_reg <= '0;
            for (int j = 0; j < FD; j++) begin
                slot_rd_reg[j] <= '0;
            end
        end else begin
            for (int j = 1; j < FD; j++) begin
                slot_valid_reg[j]   <= slot_valid_reg[j-1];
                slot_wr_en_reg[j]   <= slot_wr_en_reg[j-1];
                slot_is_load_reg[j] <= slot_is_load_reg[j-1];
                slot_rd_reg[j]      <= slot_rd_reg[j-1];
            end
            slot_valid_reg[0]   <= issue_accept;
            slot_wr_en_reg[0]   <= issue_accept && iissue_rd_wr_en && (iissue_rd != '0);
            slot_is_load_reg[0] <= issue_accept && iissue_is_load;
            slot_rd_reg[0]      <= iissue_rd;
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge iclk) begin
        if (irst) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

endmodule

// File: doc/riscv_dp_bypass.md
RISCV_DP_BYPASS -- requirements
Module: riscv_dp_bypass

Interface
REQ-001 Parameter MP_DATA_WIDTH, default 32, operand and result width.
REQ-002 Parameter MP_REGFILE_ADDR_WIDTH, default 5, register address width.
REQ-003 Parameter MP_NUM_SRC, default 2, number of source operands per decode instruction, range 1..4.
REQ-004 Parameter MP_FWD_DEPTH, default 3, number of in-flight tracking slots (slot 0 = execute, slot 1 = memory, slot 2 = writeback, ...), range 1..8.
REQ-005 Parameter MP_LOAD_READY_SLOT, default 2, first slot index at which load data is valid, range 1..MP_FWD_DEPTH-1.
REQ-006 iclk  in  1  clock, all state on rising edge.
REQ-007 irst  in  1  reset, synchronous, active-high.
REQ-008 iissue_valid  in  1  decode holds a valid instruction.
REQ-009 iissue_rd  in  MP_REGFILE_ADDR_WIDTH  decode destination register.
REQ-010 iissue_rd_wr_en  in  1  decode instruction writes rd.
REQ-011 iissue_is_load  in  1  decode instruction is a load.
REQ-012 iflush  in  1  kill decode instruction (taken branch/jump).
REQ-013 isrc_addr  in  MP_NUM_SRC*MP_REGFILE_ADDR_WIDTH  decode source addresses, source i at bits [i*AW +: AW].
REQ-014 isrc_rf_data  in  MP_NUM_SRC*MP_DATA_WIDTH  regfile read data per source.
REQ-015 islot_result  in  MP_FWD_DEPTH*MP_DATA_WIDTH  result data currently held by slot j at [j*DW +: DW].
REQ-016 osrc_data  out  MP_NUM_SRC*MP_DATA_WIDTH  resolved operand per source.
REQ-017 osrc_fwd  out  MP_NUM_SRC  1 = source i taken from a slot.
REQ-018 ostall  out  1  load-use hazard; hold fetch/decode this cycle.
REQ-019 ostall_cnt  out  32  count of stall cycles, saturating.

Function
REQ-020 Each slot SHALL hold {valid, rd, wr_en, is_load}; wr_en SHALL be stored as 0 when rd = 0.
REQ-021 Every cycle slot j SHALL load slot j-1 for j = 1..MP_FWD_DEPTH-1; the entry leaving the last slot is discarded.
REQ-022 Slot 0 SHALL load the decode entry when iissue_valid=1, iflush=0, ostall=0; otherwise slot 0 SHALL load a bubble (valid=0).
REQ-023 Per source i: if address = 0, osrc_data = 0 and osrc_fwd = 0.
REQ-024 Otherwise the lowest-index (youngest) slot j with valid & wr_en & rd = address SHALL be the match; older matches SHALL be ignored.
REQ-025 Match is ready if is_load = 0 or j >= MP_LOAD_READY_SLOT; ready match SHALL drive osrc_data = islot_result[j], osrc_fwd = 1.
REQ-026 No match SHALL drive osrc_data = isrc_rf_data, osrc_fwd = 0.
REQ-027 Not-ready match on any source with iissue_valid=1 SHALL assert ostall; osrc_data for that source is don't-care.
REQ-028 ostall SHALL be forced 0 when iflush=1 or iissue_valid=0 (flush wins over stall).
REQ-029 osrc_data, osrc_fwd, ostall SHALL be combinational from inputs and slot state (zero-cycle latency); slot update latency 1 cycle.
REQ-030 ostall_cnt SHALL increment by 1 each cycle ostall=1 and saturate at 32'hFFFF_FFFF.
REQ-031 Load in slot 0 hit by a dependent decode instruction SHALL stall exactly MP_LOAD_READY_SLOT cycles before forwarding.

Reset
REQ-032 irst=1 at a rising edge SHALL clear all slot valid bits and ostall_cnt to 0; reset takes priority over all other inputs including mid-stall.
REQ-033 After reset ostall = 0, osrc_fwd = 0, osrc_data = isrc_rf_data (or 0 for address 0).

Verification
REQ-034 ALU chain: issue add x5 then dependent on x5 next cycle, islot_result[0]=32'h0000_1234 -> osrc_data source 0 = 32'h0000_1234, osrc_fwd[0]=1, ostall=0.
REQ-035 Load-use, defaults: lw x7 then add reading x7 -> ostall=1 for 2 cycles, ostall_cnt 0->2, then forward islot_result[2]=32'hDEAD_BEEF.
REQ-036 Youngest wins: x3 written in slot 2 (32'h1111_1111) and slot 0 (32'h2222_2222) -> osrc_data = 32'h2222_2222.
REQ-037 x0 and flush: source address 0 with slot match on rd=0 -> osrc_data = 0; load-use with iflush=1 -> ostall=0, slot 0 bubble, counter unchanged.
REQ-038 Reset mid-stall: irst during load-use stall -> next cycle all slots invalid, ostall=0, ostall_cnt=0, osrc_data = isrc_rf_data.
REQ-039 Counter saturation: preload via 2^32 stall cycles or forced state 32'hFFFF_FFFE plus 3 stall cycles -> ostall_cnt = 32'hFFFF_FFFF.
